// File: rtl/hilo_ctrl.sv
// hilo_ctrl
// Sequencer for the HI/LO result registers of the multiply/divide path.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from issue, starts and
// steps an external iterative unit, drives LO/HI write enables and source
// selects, and stalls issue while a result is pending.
//
// Optional feature macro: HILO_DIV0_SKIP_EN
//   defined   : a divide accepted with div_zero=1 is dropped (no run, no write)
//   undefined : div_zero is ignored, every divide runs and writes back
//
// Ports:
//   clk, resetn         clock (rising edge), async active-low reset
//   op_valid, op        HI/LO instruction presented by issue, opcode 0..7
//   squashn             0 = presented instruction is squashed
//   div_zero            divisor is zero (sampled at accept)
//   op_stall            issue must hold its instruction
//   busy                multiply/divide in flight
//   unit_start          one-cycle start pulse to the iterative unit
//   unit_step           advance the unit by one iteration
//   unit_signed         latched signedness of the last MUL/DIV
//   unit_is_div         latched divide flag of the last MUL/DIV
//   lo_en, hi_en        LO/HI write enables
//   lo_sel, hi_sel      0 = unit result, 1 = rs operand
//   mf_sel              read mux, 0 = LO, 1 = HI
module hilo_ctrl #(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       op_valid,
  input  logic [2:0] op,
  input  logic       squashn,
  input  logic       div_zero,
  output logic       op_stall,
  output logic       busy,
  output logic       unit_start,
  output logic       unit_step,
  output logic       unit_signed,
  output logic       unit_is_div,
  output logic       lo_en,
  output logic       hi_en,
  output logic       lo_sel,
  output logic       hi_sel,
  output logic       mf_sel
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

`ifdef HILO_DIV0_SKIP_EN
  localparam logic DIV0_SKIP = 1'b1;
`else
  localparam logic DIV0_SKIP = 1'b0;
`endif

  state_t     state, state_next;
  logic [5:0] count, count_next;
  logic       first_run, first_run_next;
  logic       sgn_q, sgn_next;
  logic       div_q, div_next;

  logic accept;
  logic is_muldiv;
  logic is_div_op;
  logic skip_div;

  // resetn gates acceptance so that no enable can fire while reset is held
  assign op_stall  = op_valid && (state != IDLE);
  assign accept    = resetn && op_valid && squashn && !op_stall;
  assign is_muldiv = !op[2];
  assign is_div_op = is_muldiv && op[1];
  assign skip_div  = DIV0_SKIP && is_div_op && div_zero;

  // State register; first_run marks the cycle that carries unit_start
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      count     <= 6'd0;
      first_run <= 1'b0;
      sgn_q     <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      first_run <= first_run_next;
      sgn_q     <= sgn_next;
      div_q     <= div_next;
    end
  end

  // Next-state logic: the counter is loaded with N-1 so RUN lasts N cycles
  always_comb begin
    state_next     = state;
    count_next     = count;
    first_run_next = 1'b0;
    sgn_next       = sgn_q;
    div_next       = div_q;
    case (state)
      IDLE: begin
        if (accept && is_muldiv) begin
          sgn_next = !op[0];
          div_next = op[1];
          if (!skip_div) begin
            state_next     = RUN;
            count_next     = op[1] ? DIV_LOAD : MUL_LOAD;
            first_run_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (count == 6'd0) begin
          state_next = WB;
        end else begin
          count_next = count - 6'd1;
        end
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs: unit controls from state only; enables and selects also
  // depend on the accepted op in IDLE
  always_comb begin
    busy        = (state != IDLE);
    unit_step   = (state == RUN);
    unit_start  = (state == RUN) && first_run;
    unit_signed = sgn_q;
    unit_is_div = div_q;
    lo_en       = 1'b0;
    hi_en       = 1'b0;
    lo_sel      = 1'b0;
    hi_sel      = 1'b0;
    mf_sel      = 1'b0;
    if (state == WB) begin
      lo_en = 1'b1;
      hi_en = 1'b1;
    end else if (accept) begin
      case (op)
        3'd4: begin
          hi_en  = 1'b1;
          hi_sel = 1'b1;
        end
        3'd5: begin
          lo_en  = 1'b1;
          lo_sel = 1'b1;
        end
        3'd6: begin
          mf_sel = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Testbench for hilo_ctrl (MUL_CYCLES=4, DIV_CYCLES=6).
// Each cycle's expected output vector is queued as stimulus is driven and
// popped for comparison at the following falling edge. Small LO/HI register
// models follow the DUT enables so register contents can be checked too.
module tb_hilo_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 6;
  localparam logic [31:0] RS_VAL   = 32'h1234_5678;
  localparam logic [31:0] PROD_VAL = 32'hCAFE_0001;

  logic       clk = 1'b0;
  logic       resetn;
  logic       op_valid;
  logic [2:0] op;
  logic       squashn;
  logic       div_zero;
  logic       op_stall, busy, unit_start, unit_step, unit_signed, unit_is_div;
  logic       lo_en, hi_en, lo_sel, hi_sel, mf_sel;

  int checks = 0;
  int errors = 0;
  logic [10:0] expQueue[$];
  logic        expSigned;
  logic        expDiv;
  logic [31:0] loReg;
  logic [31:0] hiReg;

  hilo_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
    .squashn(squashn), .div_zero(div_zero), .op_stall(op_stall),
    .busy(busy), .unit_start(unit_start), .unit_step(unit_step),
    .unit_signed(unit_signed), .unit_is_div(unit_is_div),
    .lo_en(lo_en), .hi_en(hi_en), .lo_sel(lo_sel), .hi_sel(hi_sel),
    .mf_sel(mf_sel)
  );

  always #5 clk = ~clk;

  // LO/HI registers written under DUT control
  always @(posedge clk) begin
    if (lo_en) loReg <= lo_sel ? RS_VAL : PROD_VAL;
    if (hi_en) hiReg <= hi_sel ? RS_VAL : PROD_VAL;
  end

  wire [10:0] obsVec = {op_stall, busy, unit_start, unit_step, unit_signed,
                        unit_is_div, lo_en, hi_en, lo_sel, hi_sel, mf_sel};

  // Expected vector; latched signedness/divide flags come from bench state
  function automatic logic [10:0] ev(input logic stall, bsy, start, step,
                                     input logic le, he, ls, hs, mf);
    return {stall, bsy, start, step, expSigned, expDiv, le, he, ls, hs, mf};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic v,
                               input logic [2:0] o, input logic sq,
                               input logic dz, input logic [10:0] expected);
    logic [10:0] e;
    resetn   = rst;
    op_valid = v;
    op       = o;
    squashn  = sq;
    div_zero = dz;
    expQueue.push_back(expected);
    @(negedge clk);
    e = expQueue.pop_front();
    checkOutput(tag, {21'b0, obsVec}, {21'b0, e});
    @(posedge clk);
    #1;
  endtask

  // Accept a MUL/DIV, then run N step cycles and the WB cycle while
  // optionally holding another op at issue
  task automatic runMulDiv(input string tag, input logic [2:0] o, input int n,
                           input logic dz, input logic holdV,
                           input logic [2:0] holdOp);
    applyStimulus({tag, "_accept"}, 1'b1, 1'b1, o, 1'b1, dz,
                  ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    expSigned = ~o[0];
    expDiv    = o[1];
    for (int i = 1; i <= n; i++) begin
      applyStimulus($sformatf("%s_run%0d", tag, i), 1'b1, holdV, holdOp, 1'b1,
                    1'b0, ev(holdV, 1, (i == 1), 1, 0, 0, 0, 0, 0));
    end
    applyStimulus({tag, "_wb"}, 1'b1, holdV, holdOp, 1'b1, 1'b0,
                  ev(holdV, 1, 0, 0, 1, 1, 0, 0, 0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op = 3'd0; squashn = 1'b1; div_zero = 1'b0;
    expSigned = 1'b0; expDiv = 1'b0;
    loReg = 32'h0; hiReg = 32'h0;
    @(posedge clk);
    #1;

    // Reset state, then a quiet idle cycle
    applyStimulus("reset_idle", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0));
    applyStimulus("idle_quiet", 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0));

    // MULT with MFLO held at issue, then MFLO and MFHI accepted
    runMulDiv("mult", 3'd0, MUL_N, 1'b0, 1'b1, 3'd7);
    applyStimulus("mflo_accept", 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0));
    checkOutput("lo_after_mult", loReg, PROD_VAL);
    applyStimulus("mfhi_accept", 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,1));

    // DIVU with nothing waiting at issue
    runMulDiv("divu", 3'd3, DIV_N, 1'b0, 1'b0, 3'd0);
    applyStimulus("divu_idle", 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0));

    // Squashed MTHI has no effect, unsquashed one writes HI from rs
    applyStimulus("mthi_squash", 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0));
    checkOutput("hi_kept", hiReg, PROD_VAL);
    applyStimulus("mthi_accept", 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, ev(0,0,0,0,0,1,0,1,0));
    checkOutput("hi_after_mthi", hiReg, RS_VAL);

    // MULTU followed by MTLO: MTLO waits for WB and then overwrites LO
    runMulDiv("multu", 3'd1, MUL_N, 1'b0, 1'b1, 3'd5);
    applyStimulus("mtlo_after_wb", 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, ev(0,0,0,0,1,0,1,0,0));
    checkOutput("lo_rs_not_product", loReg, RS_VAL);

    // Divide by zero
`ifdef HILO_DIV0_SKIP_EN
    applyStimulus("div0_accept", 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, ev(0,0,0,0,0,0,0,0,0));
    expSigned = 1'b1;
    expDiv    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("div0_idle%0d", i), 1'b1, 1'b0, 3'd0, 1'b1, 1'b0,
                    ev(0,0,0,0,0,0,0,0,0));
    end
    checkOutput("lo_kept_div0", loReg, RS_VAL);
`else
    runMulDiv("div0", 3'd2, DIV_N, 1'b1, 1'b0, 3'd0);
    applyStimulus("div0_idle", 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0));
    checkOutput("lo_after_div0", loReg, PROD_VAL);
    applyStimulus("mtlo_restore", 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, ev(0,0,0,0,1,0,1,0,0));
`endif

    // Reset in the middle of a MULT with MTLO presented at issue
    applyStimulus("mult2_accept", 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0));
    expSigned = 1'b1;
    expDiv    = 1'b0;
    applyStimulus("mult2_run1", 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, ev(0,1,1,1,0,0,0,0,0));
    applyStimulus("mult2_run2", 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, ev(0,1,0,1,0,0,0,0,0));
    expSigned = 1'b0;
    expDiv    = 1'b0;
    applyStimulus("reset_mid_run", 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0));
    checkOutput("lo_kept_reset", loReg, RS_VAL);
    applyStimulus("mtlo_post_reset", 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, ev(0,0,0,0,1,0,1,0,0));
    applyStimulus("idle_post_reset", 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
